// File: rtl/vga_sync_generator.sv
// 640x480@60 Hz VGA timing generator: pixel divider, scan counters, raw syncs,
// a delay line that aligns syncs/blanking with the drawers' colour latency, and the registered pin stage.
module vga_sync_generator #(
   parameter int unsigned CLK_DIV    = 2,
   parameter int unsigned PIPE_DELAY = 1,
   parameter int unsigned H_VIS      = 640,
   parameter int unsigned H_FP       = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BP       = 48,
   parameter int unsigned V_VIS      = 480,
   parameter int unsigned V_FP       = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BP       = 33
) (
   input  logic       clock,
   input  logic       reset,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       video_on,
   output logic       pixel_tick,
   output logic       frame_start,
   input  logic [3:0] red,
   input  logic [3:0] green,
   input  logic [3:0] blue,
   output logic [3:0] vga_r,
   output logic [3:0] vga_g,
   output logic [3:0] vga_b,
   output logic       hsync,
   output logic       vsync
);

   localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
   localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0]  H_VIS_L = 10'(H_VIS);
   localparam logic [9:0]  V_VIS_L = 10'(V_VIS);
   localparam logic [9:0]  HS_FIRST = 10'(H_VIS + H_FP);
   localparam logic [9:0]  HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [9:0]  VS_FIRST = 10'(V_VIS + V_FP);
   localparam logic [9:0]  VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
   localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   // Delay-line word is {video_on, hs, vs}; idle means blanked with both syncs released.
   localparam logic [2:0] DLY_IDLE = 3'b011;

   logic [DIV_W-1:0] r_div_cnt;
   logic [9:0]       r_h_cnt;
   logic [9:0]       r_v_cnt;
   logic             w_hs_raw;
   logic             w_vs_raw;
   logic [2:0]       w_raw;
   logic [2:0]       w_dly;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_div_cnt <= '0;
         r_h_cnt   <= '0;
         r_v_cnt   <= '0;
      end else begin
         r_div_cnt <= pixel_tick ? '0 : r_div_cnt + DIV_W'(1);
         if (pixel_tick) begin
            if (r_h_cnt == H_LAST) begin
               r_h_cnt <= '0;
               r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 10'd1;
            end else begin
               r_h_cnt <= r_h_cnt + 10'd1;
            end
         end
      end
   end

   always_comb begin
      pixel_tick  = (r_div_cnt == DIV_LAST);
      x           = r_h_cnt;
      y           = r_v_cnt;
      video_on    = (r_h_cnt < H_VIS_L) && (r_v_cnt < V_VIS_L);
      frame_start = (r_h_cnt == '0) && (r_v_cnt == '0) && (r_div_cnt == '0);
      w_hs_raw    = !((r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST));
      w_vs_raw    = !((r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST));
      w_raw       = {video_on, w_hs_raw, w_vs_raw};
   end

   generate
      if (PIPE_DELAY == 0) begin : g_direct
         assign w_dly = w_raw;
      end else begin : g_pipe
         logic [2:0] r_pipe [PIPE_DELAY];

         always_ff @(posedge clock) begin
            if (reset) begin
               for (int unsigned i = 0; i < PIPE_DELAY; i++) r_pipe[i] <= DLY_IDLE;
            end else begin
               r_pipe[0] <= w_raw;
               for (int unsigned i = 1; i < PIPE_DELAY; i++) r_pipe[i] <= r_pipe[i-1];
            end
         end

         assign w_dly = r_pipe[PIPE_DELAY-1];
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) begin
         hsync <= 1'b1;
         vsync <= 1'b1;
         vga_r <= '0;
         vga_g <= '0;
         vga_b <= '0;
      end else begin
         hsync <= w_dly[1];
         vsync <= w_dly[0];
         vga_r <= w_dly[2] ? red   : '0;
         vga_g <= w_dly[2] ? green : '0;
         vga_b <= w_dly[2] ? blue  : '0;
      end
   end

endmodule

// File: tb/tb_vga_sync_generator.sv
// Directed bench: three generator instances (default timing, CLK_DIV=1/PIPE_DELAY=0, and a
// miniature frame so vertical timing fits a short run) checked against hand-computed clock counts.
module tb_vga_sync_generator;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset;

   // Instance A: CLK_DIV=2, PIPE_DELAY=1, 640x480 timing.
   logic [9:0] a_x, a_y;
   logic       a_vid, a_tick, a_fs, a_hs, a_vs;
   logic [3:0] a_red, a_r, a_g, a_b;

   // Instance B: CLK_DIV=1, PIPE_DELAY=0.
   logic [9:0] b_x, b_y;
   logic       b_vid, b_tick, b_fs, b_hs, b_vs;
   logic [3:0] b_r, b_g, b_b;

   // Instance C: 15x8 total frame, CLK_DIV=2, PIPE_DELAY=2.
   logic [9:0] c_x, c_y;
   logic       c_vid, c_tick, c_fs, c_hs, c_vs;
   logic [3:0] c_r, c_g, c_b;

   vga_sync_generator #(.CLK_DIV(2), .PIPE_DELAY(1)) dut_a (
      .clock(clock), .reset(reset), .x(a_x), .y(a_y), .video_on(a_vid),
      .pixel_tick(a_tick), .frame_start(a_fs),
      .red(a_red), .green(4'hF), .blue(4'hF),
      .vga_r(a_r), .vga_g(a_g), .vga_b(a_b), .hsync(a_hs), .vsync(a_vs));

   vga_sync_generator #(.CLK_DIV(1), .PIPE_DELAY(0)) dut_b (
      .clock(clock), .reset(reset), .x(b_x), .y(b_y), .video_on(b_vid),
      .pixel_tick(b_tick), .frame_start(b_fs),
      .red(4'h5), .green(4'h0), .blue(4'h0),
      .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .hsync(b_hs), .vsync(b_vs));

   vga_sync_generator #(.CLK_DIV(2), .PIPE_DELAY(2),
                        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_c (
      .clock(clock), .reset(reset), .x(c_x), .y(c_y), .video_on(c_vid),
      .pixel_tick(c_tick), .frame_start(c_fs),
      .red(4'h0), .green(4'h0), .blue(4'hF),
      .vga_r(c_r), .vga_g(c_g), .vga_b(c_b), .hsync(c_hs), .vsync(c_vs));

   // Drawer stand-in for instance A: one-clock registered colour, lit only at x==10.
   always @(posedge clock) a_red <= (a_x == 10'd10) ? 4'hF : 4'h0;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int qat(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   function automatic bit vis_a(input int j);
      return (((j / 2) % 800) < 640) && (((j / 1600) % 525) < 480);
   endfunction

   function automatic bit vis_c(input int j);
      return (((j / 2) % 15) < 8) && (((j / 30) % 8) < 4);
   endfunction

   localparam int N = 3300;

   int a_hfall[$], a_hrise[$], a_wrap[$], a_fsq[$];
   int b_hfall[$], b_hrise[$], b_wrap[$];
   int c_hfall[$], c_hrise[$], c_vfall[$], c_vrise[$], c_fsq[$];
   int err_a_xy, err_a_tick, err_a_vid, err_a_blank, a_red_cnt, a_red_first;
   int err_b_tick, err_b_x, err_c_xy, err_c_blank, err_c_fsgap;
   logic [9:0] pa_x, pb_x, pc_x;
   logic pa_hs, pb_hs, pc_hs, pc_vs;
   int waited;

   initial begin
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      // Run instance A into its horizontal sync region, then reset mid-line.
      waited = 0;
      while (a_x !== 10'd700 && waited < 3000) begin
         @(posedge clock); #1;
         waited++;
      end
      chk("reach_x700", 32'(a_x), 700);
      chk("pre_reset_hsync_low", 32'(a_hs), 0);

      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         chk("rst_x", 32'(a_x), 0);
         chk("rst_y", 32'(a_y), 0);
         chk("rst_hsync", 32'(a_hs), 1);
         chk("rst_vsync", 32'(a_vs), 1);
         chk("rst_rgb", 32'({a_r, a_g, a_b}), 0);
      end
      reset = 1'b0;

      chk("rel_fs_a", 32'(a_fs), 1);
      chk("rel_fs_b", 32'(b_fs), 1);
      chk("rel_fs_c", 32'(c_fs), 1);
      chk("rel_vid_a", 32'(a_vid), 1);
      chk("rel_tick_a", 32'(a_tick), 0);
      chk("rel_tick_b", 32'(b_tick), 1);
      chk("rel_b_hs", 32'(b_hs), 1);

      err_a_xy = 0; err_a_tick = 0; err_a_vid = 0; err_a_blank = 0;
      a_red_cnt = 0; a_red_first = -1;
      err_b_tick = 0; err_b_x = 0; err_c_xy = 0; err_c_blank = 0; err_c_fsgap = 0;
      pa_x = a_x; pb_x = b_x; pc_x = c_x;
      pa_hs = a_hs; pb_hs = b_hs; pc_hs = c_hs; pc_vs = c_vs;

      // Sample index k counts clocks after reset release; k=0 is the state shown right now.
      for (int k = 0; k < N; k++) begin
         if (k > 0) begin
            @(posedge clock); #1;
         end
         if (a_x !== 10'((k / 2) % 800) || a_y !== 10'((k / 1600) % 525)) err_a_xy++;
         if (a_tick !== 1'(k % 2)) err_a_tick++;
         if (a_vid !== vis_a(k)) err_a_vid++;
         if (a_b !== ((k >= 2 && vis_a(k - 2)) ? 4'hF : 4'h0)) err_a_blank++;
         if (a_r === 4'hF && k < 1600) begin
            a_red_cnt++;
            if (a_red_first < 0) a_red_first = k;
         end
         if (a_fs === 1'b1) a_fsq.push_back(k);
         if (b_tick !== 1'b1) err_b_tick++;
         if (b_x !== 10'(k % 800)) err_b_x++;
         if (c_x !== 10'((k / 2) % 15) || c_y !== 10'((k / 30) % 8)) err_c_xy++;
         if (c_b !== ((k >= 3 && vis_c(k - 3)) ? 4'hF : 4'h0)) err_c_blank++;
         if (c_fs === 1'b1) begin
            if (c_fsq.size() > 0 && k - c_fsq[c_fsq.size()-1] != 240) err_c_fsgap++;
            c_fsq.push_back(k);
         end
         if (k > 0) begin
            if (pa_hs && !a_hs) a_hfall.push_back(k);
            if (!pa_hs && a_hs) a_hrise.push_back(k);
            if (a_x == 0 && pa_x != 0) a_wrap.push_back(k);
            if (pb_hs && !b_hs) b_hfall.push_back(k);
            if (!pb_hs && b_hs) b_hrise.push_back(k);
            if (b_x == 0 && pb_x != 0) b_wrap.push_back(k);
            if (pc_hs && !c_hs) c_hfall.push_back(k);
            if (!pc_hs && c_hs) c_hrise.push_back(k);
            if (pc_vs && !c_vs) c_vfall.push_back(k);
            if (!pc_vs && c_vs) c_vrise.push_back(k);
         end
         pa_x = a_x; pb_x = b_x; pc_x = c_x;
         pa_hs = a_hs; pb_hs = b_hs; pc_hs = c_hs; pc_vs = c_vs;
      end

      chk("a_xy_track", err_a_xy, 0);
      chk("a_tick_pattern", err_a_tick, 0);
      chk("a_video_on", err_a_vid, 0);
      chk("a_blanking", err_a_blank, 0);
      chk("a_line_wrap0", qat(a_wrap, 0), 1600);
      chk("a_line_wrap1", qat(a_wrap, 1), 3200);
      chk("a_hsync_fall0", qat(a_hfall, 0), 1314);
      chk("a_hsync_rise0", qat(a_hrise, 0), 1506);
      chk("a_hsync_fall1", qat(a_hfall, 1), 2914);
      chk("a_align_first", a_red_first, 22);
      chk("a_align_count", a_red_cnt, 2);
      chk("a_frame_start_count", a_fsq.size(), 1);

      chk("b_tick_high", err_b_tick, 0);
      chk("b_x_track", err_b_x, 0);
      chk("b_line_wrap0", qat(b_wrap, 0), 800);
      chk("b_line_wrap3", qat(b_wrap, 3), 3200);
      chk("b_hsync_fall0", qat(b_hfall, 0), 657);
      chk("b_hsync_rise0", qat(b_hrise, 0), 753);
      chk("b_hsync_fall1", qat(b_hfall, 1), 1457);

      chk("c_xy_track", err_c_xy, 0);
      chk("c_blanking", err_c_blank, 0);
      chk("c_hsync_fall0", qat(c_hfall, 0), 23);
      chk("c_hsync_rise0", qat(c_hrise, 0), 29);
      chk("c_vsync_fall0", qat(c_vfall, 0), 153);
      chk("c_vsync_rise0", qat(c_vrise, 0), 213);
      chk("c_vsync_fall1", qat(c_vfall, 1), 393);
      chk("c_frame_start_count", c_fsq.size(), 14);
      chk("c_frame_start_gap", err_c_fsgap, 0);
      chk("c_frame_start_last", qat(c_fsq, 13), 3120);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_sync_generator.md
# vga_sync_generator

Free-running 640x480@60 Hz VGA timing generator and pixel output stage. It produces the `x`/`y` scan coordinates that pixel-drawing blocks (box drawers, sprite layers) consume. It also takes their registered 4-bit RGB back and drives the monitor pins. Colour is forced to black outside the visible area, and hsync/vsync are delayed to line up with the drawers' pipeline latency.

## Interface
Parameters:
- `CLK_DIV`, 2: system clocks per pixel (50 MHz board clock gives a 25 MHz pixel rate); legal values ≥1.
- `PIPE_DELAY`, 1: clock cycles between `x`/`y` changing and the matching colour arriving on `red`/`green`/`blue`; legal values ≥0.
- `H_VIS`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48: horizontal timing in pixels.
- `V_VIS`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33: vertical timing in lines.

Ports:
- `clock`, in, 1: system clock. One clock domain only.
- `reset`, in, 1: synchronous, active-high.
- `x`, out, 10: horizontal counter, 0..799.
- `y`, out, 10: vertical counter, 0..524.
- `video_on`, out, 1: high when `x < H_VIS` and `y < V_VIS`; undelayed.
- `pixel_tick`, out, 1: high on the last clock of each pixel period.
- `frame_start`, out, 1: one-clock pulse when the counters enter (0,0).
- `red`/`green`/`blue`, in, 4 each: colour from the drawers, valid `PIPE_DELAY` clocks after the `x`/`y` it belongs to.
- `vga_r`/`vga_g`/`vga_b`, out, 4 each: colour to the monitor pins, registered.
- `hsync`/`vsync`, out, 1 each: sync pins, active-low, registered.

## Operation
- Divider:
  - `div_cnt` counts 0..`CLK_DIV`-1 and wraps.
  - `pixel_tick` = (`div_cnt` == `CLK_DIV`-1). With `CLK_DIV`=1, `pixel_tick` is constantly high.
- Horizontal counter `h_cnt`:
  - Advances only on `pixel_tick`.
  - At 799 (`H_TOTAL`-1) it wraps to 0; otherwise +1.
- Vertical counter `v_cnt`:
  - Advances only on `pixel_tick` with `h_cnt` == 799.
  - At 524 it wraps to 0; otherwise +1.
- `x` = `h_cnt`, `y` = `v_cnt`, driven directly from the registers. Drawers do their own range checks.
- Raw sync signals:
  - `hs_raw` is low when 656 ≤ `h_cnt` ≤ 751.
  - `vs_raw` is low when 490 ≤ `v_cnt` ≤ 491.
  - All boundaries are computed from the parameters, not hard-coded.
- `frame_start` = (`h_cnt`==0 && `v_cnt`==0 && `div_cnt`==0), combinational.
- Alignment delay line:
  - {`video_on`, `hs_raw`, `vs_raw`} pass through a shift register of depth `PIPE_DELAY`, clocked every clock (not every `pixel_tick`).
  - `PIPE_DELAY`=0 means a direct wire.
- Output register, updated every clock:
  - `hsync` <= delayed `hs_raw`; `vsync` <= delayed `vs_raw`.
  - `vga_r/g/b` <= delayed `video_on` ? `red/green/blue` : 0.
- Reset (synchronous) sets:
  - `div_cnt`, `h_cnt`, `v_cnt` to 0.
  - Every delay-line stage to inactive (`video_on`=0, `hs`=1, `vs`=1).
  - `hsync`=`vsync`=1 and `vga_r/g/b`=0.
- Reset mid-frame: the next clock restarts at (0,0) with no sync glitch low; the delay line is flushed to the inactive values.
- Arithmetic: all compares are unsigned 10-bit. The maximum count 799 fits in 10 bits; no overflow is possible.

## Timing
- Reset values while `reset` is high and on the first clock after release:
  - `x`=0, `y`=0.
  - `video_on`=1 (the (0,0) pixel is visible).
  - `pixel_tick`=(`CLK_DIV`==1), `frame_start`=1.
  - `hsync`=1, `vsync`=1, RGB=0.
- Periods with `CLK_DIV`=2:
  - Line = 1600 clocks.
  - Frame = 525 × 1600 = 840000 clocks.
  - hsync low for 192 clocks, starting 1312 clocks after line start.
  - vsync low for 2 lines = 3200 clocks.
- Pin latency:
  - Sync pins lag the counter transition by `PIPE_DELAY`+1 clocks.
  - `red` sampled at clock t corresponds to `x`/`y` at clock t-`PIPE_DELAY` and appears on `vga_r` at t+1.
- `frame_start` is high for exactly one clock per frame, for every `CLK_DIV`.
- There is no handshake and no stalling: the generator is free-running and ignores the inputs except `reset`.

## Test plan
- Reset behaviour: hold `reset` for 5 clocks mid-frame (e.g. `x`=700), then release. Required: `x`=`y`=0, `hsync`=`vsync`=1, RGB=0 during reset; `frame_start`=1 on the first cycle after release.
- Horizontal timing, `CLK_DIV`=2, `PIPE_DELAY`=1: measure one line. Required: `hsync` falls 1314 clocks after `h_cnt` enters 0 and stays low 192 clocks; line period 1600 clocks.
- Vertical timing and frame length: run 2 full frames. Required: `vsync` low for exactly 3200 clocks starting at line 490 (+2 clocks of delay); `frame_start` pulses exactly 840000 clocks apart.
- Blanking: drive `red`=`green`=`blue`=4'hF constantly. Required: `vga_*`=F only for delayed `video_on`; 0 during `x` 640..799 and `y` 480..524.
- Alignment, `PIPE_DELAY`=1: feed back `red` = registered (`x`==10 ? F : 0). Required: `vga_r`=F in exactly the clocks whose delayed coordinate is `x`=10 (2 clocks per line at `CLK_DIV`=2).
- `CLK_DIV`=1, `PIPE_DELAY`=0: `pixel_tick` stays high; line = 800 clocks; `hsync` low for 96 clocks starting 657 clocks after `h_cnt`=0.
